// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_driver_if                                             |
// | Brief    : Value/strobe/blank inputs and scanned SEL/SEG outputs of the    |
// |            4-digit seven-segment scan driver.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        blank;
  logic [3:0]  SEL;
  logic [6:0]  SEG;
  logic        frame_start;

  modport master (
    output data_in, data_valid, blank,
    input  SEL, SEG, frame_start
  );

  modport slave (
    input  data_in, data_valid, blank,
    output SEL, SEG, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                                |
// | Brief    : Time-multiplexed 4-digit common-anode hex display driver with   |
// |            tear-free shadow register. Optional SEG7_SCAN_LZB_EN macro      |
// |            enables leading-zero blanking of digits 3..1.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int CLK_Freq  = 50000000,
  parameter int SCAN_Freq = 1000
) (
  input  wire logic          CLK_50,
  input  wire logic          nCLR,
  seg7_scan_driver_if.slave  bus
);

  // Divider must be at least 2 for the prescaler to make sense.
  localparam int               c_DIV     = CLK_Freq / SCAN_Freq;
  localparam int               c_CNT_W   = $clog2(c_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_pending;
  logic [15:0]        r_shadow;
  logic [3:0]         r_sel;
  logic [6:0]         r_seg;
  logic               r_frame_start;

  logic               w_tick;
  logic               w_boundary;
  logic [1:0]         w_idx_next;
  logic [15:0]        w_shadow_d;
  logic [3:0]         w_nibble;
  logic [6:0]         w_glyph;
  logic [3:0]         w_sel;
  logic               w_lead_zero;

  assign w_tick     = (r_cnt == c_CNT_MAX);
  assign w_idx_next = r_idx + 2'd1;
  assign w_boundary = w_tick && (r_idx == 2'd3);

  // Decode from the value the shadow is about to hold, so a frame-boundary
  // strobe appears on digit 0 of the very next frame.
  assign w_shadow_d = w_boundary ? (bus.data_valid ? bus.data_in : r_pending)
                                 : r_shadow;
  assign w_nibble   = w_shadow_d[{w_idx_next, 2'b00} +: 4];
  assign w_sel      = ~(4'b0001 << w_idx_next);

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

`ifdef SEG7_SCAN_LZB_EN
  // A digit is a leading zero when it and every higher nibble are zero;
  // digit 0 always shows.
  always_comb begin
    w_lead_zero = 1'b0;
    case (w_idx_next)
      2'd3:    w_lead_zero = (w_shadow_d[15:12] == 4'h0);
      2'd2:    w_lead_zero = (w_shadow_d[15:8]  == 8'h00);
      2'd1:    w_lead_zero = (w_shadow_d[15:4]  == 12'h000);
      default: w_lead_zero = 1'b0;
    endcase
  end
`else
  assign w_lead_zero = 1'b0;
`endif

  always_ff @(posedge CLK_50 or negedge nCLR) begin
    if (!nCLR) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_pending     <= 16'h0000;
      r_shadow      <= 16'h0000;
      r_sel         <= 4'b1111;
      r_seg         <= 7'h7F;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_tick ? '0 : r_cnt + 1'b1;
      r_shadow      <= w_shadow_d;
      r_frame_start <= w_boundary;
      if (bus.data_valid) begin
        r_pending <= bus.data_in;
      end
      if (w_tick) begin
        r_idx <= w_idx_next;
        if (bus.blank) begin
          r_sel <= 4'b1111;
          r_seg <= 7'h7F;
        end else begin
          r_sel <= w_sel;
          r_seg <= w_lead_zero ? 7'h7F : w_glyph;
        end
      end
    end
  end

  assign bus.SEL         = r_sel;
  assign bus.SEG         = r_seg;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_driver                                             |
// | Brief    : Directed scoreboard bench for seg7_scan_driver at DIV=4.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic nCLR;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];

`ifdef SEG7_SCAN_LZB_EN
  localparam logic [6:0] c_HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] c_HI_ZERO = 7'h40;
`endif

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.CLK_Freq(16), .SCAN_Freq(4)) dut (
    .CLK_50 (clk),
    .nCLR   (nCLR),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] sel, input logic [6:0] seg);
    exp_t e;
    e.sel = sel;
    e.seg = seg;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      check(tag, {5'b0, bus.SEL, bus.SEG}, {5'b0, e.sel, e.seg});
    end
  endtask

  task automatic check_fs(input string tag, input logic exp);
    check(tag, {15'b0, bus.frame_start}, {15'b0, exp});
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic do_reset();
    nCLR = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    nCLR = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    bus.data_in    = 16'h0000;
    bus.data_valid = 1'b0;
    bus.blank      = 1'b0;
    do_reset();

    // Reset then idle scan
    check("reset_out", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b1111, 7'h7F});
    check_fs("reset_fs", 1'b0);
    push(4'b1101, 7'h40); push(4'b1011, 7'h40); push(4'b0111, 7'h40); push(4'b1110, 7'h40);
    goto_cyc(3);  check("idle_c3", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b1111, 7'h7F});
    goto_cyc(4);  pop_check("idle_d1");
    goto_cyc(8);  pop_check("idle_d2");
    goto_cyc(12); pop_check("idle_d3");
    goto_cyc(15); check_fs("fs_c15", 1'b0);
    goto_cyc(16); pop_check("idle_d0"); check_fs("fs_c16", 1'b1);
    goto_cyc(17); check_fs("fs_c17", 1'b0);

    // Mid-frame strobe waits for the frame boundary
    goto_cyc(18); strobe(16'h1234);
    push(4'b1101, 7'h40); push(4'b1011, 7'h40); push(4'b0111, 7'h40);
    push(4'b1110, 7'h19); push(4'b1101, 7'h30); push(4'b1011, 7'h24); push(4'b0111, 7'h79);
    goto_cyc(20); pop_check("mid_old_d1");
    goto_cyc(24); pop_check("mid_old_d2");
    goto_cyc(28); pop_check("mid_old_d3");
    goto_cyc(32); pop_check("mid_new_d0"); check_fs("fs_c32", 1'b1);
    goto_cyc(36); pop_check("mid_new_d1");
    goto_cyc(40); pop_check("mid_new_d2");
    goto_cyc(44); pop_check("mid_new_d3");

    // Strobe on the boundary tick bypasses into the shadow
    push(4'b1110, 7'h21); push(4'b1101, 7'h46); push(4'b1011, 7'h03); push(4'b0111, 7'h08);
    goto_cyc(47); strobe(16'hABCD);
    pop_check("byp_d0"); check_fs("fs_c48", 1'b1);
    goto_cyc(50); strobe(16'h1111);
    goto_cyc(52); pop_check("byp_d1");
    goto_cyc(54); strobe(16'hFFFF);
    goto_cyc(56); pop_check("byp_d2");
    goto_cyc(60); pop_check("byp_d3");

    // Last strobe wins
    push(4'b1110, 7'h0E); push(4'b1101, 7'h0E); push(4'b1011, 7'h0E); push(4'b0111, 7'h0E);
    goto_cyc(64); pop_check("last_d0");
    goto_cyc(68); pop_check("last_d1");
    goto_cyc(72); pop_check("last_d2");
    goto_cyc(76); pop_check("last_d3");

    // Blank for 20 cycles
    goto_cyc(77); bus.blank = 1'b1;
    repeat (5) push(4'b1111, 7'h7F);
    goto_cyc(78); check("blank_pre_tick", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b0111, 7'h0E});
    goto_cyc(80); pop_check("blank_80"); check_fs("fs_c80", 1'b1);
    goto_cyc(84); pop_check("blank_84");
    goto_cyc(88); pop_check("blank_88");
    goto_cyc(92); pop_check("blank_92");
    goto_cyc(96); pop_check("blank_96"); check_fs("fs_c96", 1'b1);
    goto_cyc(97); bus.blank = 1'b0;
    push(4'b1101, 7'h0E);
    goto_cyc(99);  check("blank_hold_99", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b1111, 7'h7F});
    goto_cyc(100); pop_check("unblank_d1");

    // Value with zero upper nibbles, then reset mid-frame
    goto_cyc(101); strobe(16'h0050);
    push(4'b1011, 7'h0E); push(4'b0111, 7'h0E);
    push(4'b1110, 7'h40); push(4'b1101, 7'h12); push(4'b1011, c_HI_ZERO); push(4'b0111, c_HI_ZERO);
    goto_cyc(104); pop_check("z_old_d2");
    goto_cyc(108); pop_check("z_old_d3");
    goto_cyc(112); pop_check("z_d0");
    goto_cyc(116); pop_check("z_d1");
    goto_cyc(120); pop_check("z_d2");
    goto_cyc(124); pop_check("z_d3");
    goto_cyc(126);
    nCLR = 1'b0;
    #1;
    check("async_rst_out", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b1111, 7'h7F});
    check_fs("async_rst_fs", 1'b0);
    repeat (2) @(posedge clk);
    #3;
    nCLR = 1'b1;
    cyc  = 0;
    push(4'b1101, 7'h40);
    goto_cyc(3); check("rst2_c3", {5'b0, bus.SEL, bus.SEG}, {5'b0, 4'b1111, 7'h7F});
    goto_cyc(4); pop_check("rst2_d1");

    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, downstream of the counter logic and in place of a single-digit lookup. It accepts a 16-bit hex value (four nibbles), stores it in a tear-free shadow register, and scans one digit at a time at a parameterised refresh rate. Digit select and segment outputs are registered and decoded to hex glyphs.

## Interface
- CLK_Freq, 50000000: input clock frequency in Hz.
- SCAN_Freq, 1000: digit-advance rate in Hz; DIV = CLK_Freq/SCAN_Freq, must be ≥ 2.
- CLK_50  input  1  system clock, rising edge.
- nCLR  input  1  reset: one clock; reset is asynchronous and active-low.
- data_in  input  16  value to display; nibble k is shown on digit k (digit 0 = rightmost).
- data_valid  input  1  one-cycle strobe: capture data_in into the pending register.
- blank  input  1  level: while high, all digits off; the scan keeps running.
- SEL  output  4  digit enables, active-low, one-hot-low; SEL[k] drives digit k.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_start  output  1  one-cycle pulse when the shadow register is reloaded (scan wraps to digit 0).

## Operation
- Prescaler `cnt` counts from 0 to DIV-1 and then wraps to 0. `tick` is asserted when `cnt` == DIV-1.
- On tick, the digit index `idx` advances 0→1→2→3→0.
- A frame boundary is a tick with `idx` == 3.
- Pending register: loads data_in on any cycle with data_valid=1. The last strobe wins.
- Shadow register: loads pending at each frame boundary. The displayed value never changes mid-frame.
- Simultaneous data_valid and frame boundary: the shadow loads data_in directly (bypass) and pending also loads data_in.
- Decode: nibble shadow[4·idx_next+3 : 4·idx_next] maps to a hex glyph, active-low:
  - 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- `idx_next` is the index after the tick. SEL/SEG therefore change together with `idx`.
- blank=1: SEL=4'b1111 and SEG=7'h7F at the next tick. `idx`, `cnt` and the shadow continue updating.
- There is no ghosting interval. SEL and SEG update in the same cycle, so exactly one SEL bit is low whenever the display is active.

## Timing
- Reset values: `cnt`=0, `idx`=0, pending=0, shadow=0, SEL=4'b1111, SEG=7'h7F, frame_start=0.
- The first tick after reset occurs at cycle DIV-1. SEL/SEG become valid one cycle later and show digit 1 of shadow (0 → glyph 7'h40).
- Outputs are registered and update on the clock edge that follows the tick cycle.
- frame_start is high for exactly one cycle, in the same cycle as the shadow update (one cycle after the boundary tick). Its period is 4·DIV cycles.
- data_in to visible latency:
  - Captured in pending 1 cycle after the strobe.
  - Reaches the shadow at the next frame boundary, up to 4·DIV cycles later.
  - Visible on a given digit when that digit is next scanned.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). Scanning restarts from `cnt`=0 on release.
- blank changes take effect only at a tick.

## Configuration
- Macro: SEG7_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digits 3, 2, 1 are blanked (SEG=7'h7F, SEL bit still low) if that nibble and every higher nibble of the shadow are zero.
  - Digit 0 is never blanked, so shadow 16'h0000 shows a single "0".
- Undefined: all four digits always show their glyph (16'h0000 shows "0000").

## Test plan
All scenarios use CLK_Freq=16, SCAN_Freq=4 (DIV=4) and check outputs on the cycle after each tick.
1. Reset then idle. Expected:
   - SEL=1111, SEG=7F until cycle 4.
   - SEL then cycles 1101, 1011, 0111, 1110 every 4 cycles, with SEG=40 throughout.
   - frame_start pulses every 16 cycles.
2. data_valid with data_in=16'h1234 mid-frame. Expected:
   - No change to the shadow until the next frame_start.
   - Then SEL=1110 → SEG=19 ('4'), 1101 → 30 ('3'), 1011 → 24 ('2'), 0111 → 79 ('1').
3. Strobe 16'hABCD on the exact frame-boundary tick cycle. Expected:
   - The following frame shows D,C,B,A (21, 46, 03, 08) without a one-frame delay.
4. Two strobes in one frame (16'h1111, then 16'hFFFF). Expected: only FFFF appears, with SEG=0E on all digits.
5. blank=1 for 20 cycles. Expected:
   - SEL=1111, SEG=7F from the next tick.
   - frame_start continues pulsing.
   - On release, the scan resumes at the current `idx`.
6. With SEG7_SCAN_LZB_EN, shadow 16'h0050. Expected:
   - Digits 3 and 2 show SEG=7F.
   - Digit 1 shows 12 ('5') and digit 0 shows 40 ('0').
   - Asserting nCLR=0 mid-frame forces SEL=1111, SEG=7F immediately.
